temp_sensor_frontend: RTL and testbench
=======================================

Name: temp_sensor_frontend

Overview:
- Upstream stage of the AC controller; produces the 7-bit ambient `temperature` word that the controller compares against the user setpoint.
- Periodically reads an external 8-bit serial temperature sensor through a 3-wire read-only interface (CS_n, SCLK, SDO).
- Clamps each reading to 0..127 °C and smooths it with a 4-sample moving average.
- Flags a missing or faulty sensor.

Parameters:
- CLK_DIV, 4: clk cycles per SCLK half-period; legal range ≥1.
- SAMPLE_PERIOD, 1000: clk cycles between automatic sample ticks; must be > 18*CLK_DIV+2.

Ports:
- clk  input  1  system clock
- reset  input  1  reset; asynchronous, active-low
- sample_now  input  1  one-cycle request for an immediate sample
- sens_sdo  input  1  sensor serial data, MSB first
- sens_cs_n  output  1  sensor chip select, active-low
- sens_sclk  output  1  sensor serial clock, idle low
- temperature  output  7  averaged temperature, °C, unsigned
- temp_valid  output  1  one-cycle pulse when `temperature` updates
- sensor_fault  output  1  high while the last reading was 8'hFF

Behaviour:

Reset (reset=0, asynchronous):
- sens_cs_n=1, sens_sclk=0, temperature=0, temp_valid=0, sensor_fault=0.
- Period counter=0, FSM=IDLE, window fill flag cleared.
- Reset mid-transaction aborts the transaction immediately; no partial data is retained.

Period counter:
- Counts 0..SAMPLE_PERIOD-1, then wraps to 0.
- The tick is the cycle in which the counter equals SAMPLE_PERIOD-1.
- The counter runs continuously, independent of the FSM.

Trigger:
- trigger = tick OR sample_now, sampled only in IDLE.
- A tick and sample_now in the same cycle start exactly one transaction.
- Triggers arriving outside IDLE are dropped, not queued.

FSM:
- IDLE: cs_n=1, sclk=0. On trigger → CS_SETUP.
- CS_SETUP: cs_n=0 for CLK_DIV cycles → SHIFT.
- SHIFT: 8 bits. Per bit, sclk is low for CLK_DIV cycles, then high for CLK_DIV cycles.
  - sens_sdo is captured in the clk cycle where sclk goes 0→1 and shifted in MSB first.
  - After bit 7's high phase, sclk returns to 0 → CS_HOLD.
- CS_HOLD: cs_n=0, sclk=0 for CLK_DIV cycles; then cs_n=1 → PROCESS.
- PROCESS: 1 cycle, evaluates the raw byte → IDLE.

Processing of the raw byte:
- raw==8'hFF: sensor_fault←1; window and temperature unchanged; no temp_valid pulse.
- Otherwise: sensor_fault←0, then clamp:
  - raw[7]=1 (negative) → sample=0.
  - else sample=raw[6:0].
- Window: 4 entries of 7 bits; the new sample replaces the oldest.
  - If the fill flag is clear (first good sample since reset), all 4 entries load the sample and the flag is set.
- Averaging:
  - sum is 9 bits, no overflow possible (max 508).
  - temperature = sum[8:2], i.e. truncating divide by 4.

Output timing:
- temperature and temp_valid update together, the cycle after PROCESS.
- temp_valid is high exactly 18*CLK_DIV+2 cycles after the trigger cycle (T+74 at CLK_DIV=4).
- temp_valid is high for exactly 1 cycle.
- sensor_fault updates in the same cycle and holds until the next good reading.

Test Plan:
- Reset, then sensor shifts 8'd24 at default params → sclk shows 8 high pulses of 4 clk each; cs_n is low for 72 cycles; temp_valid pulses at tick+74; temperature=24.
- Successive readings 24, 28, 20, 32 after a first 24 → temperature sequence 24, 25, 24, 26 (truncation).
- Sensor returns 8'hFF (SDO held high) → sensor_fault=1, no temp_valid, temperature holds. Next reading 8'd22 → sensor_fault=0.
- Reading 8'hF6 (-10 °C) after window filled at 0 → temperature=0. Reading 8'd127 ×4 → temperature=127, no overflow.
- sample_now asserted in the same cycle as the tick → exactly one cs_n low window. sample_now mid-SHIFT → ignored, with no second transaction.
- Assert reset during SHIFT bit 3 → cs_n=1 and sclk=0 immediately. After release, the first good reading 30 fills the window → temperature=30.

Source files
------------

// File: rtl/temp_sensor_frontend.sv
// Serial temperature sensor reader with clamp, fault flag
// and 4-sample moving average for the AC controller.
module temp_sensor_frontend #(
  parameter int CLK_DIV       = 4,
  parameter int SAMPLE_PERIOD = 1000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       sample_now,
  input  logic       sens_sdo,
  output logic       sens_cs_n,
  output logic       sens_sclk,
  output logic [6:0] temperature,
  output logic       temp_valid,
  output logic       sensor_fault
);

  localparam int PW = $clog2(SAMPLE_PERIOD);
  localparam int DW = $clog2(2 * CLK_DIV + 1);

  localparam logic [PW-1:0] P_LAST   = PW'(SAMPLE_PERIOD - 1);
  localparam logic [DW-1:0] PH_END   = DW'(CLK_DIV - 1);
  localparam logic [DW-1:0] HI_START = DW'(CLK_DIV);
  localparam logic [DW-1:0] BIT_END  = DW'(2 * CLK_DIV - 1);

  typedef enum logic [2:0] {
    IDLE,
    CS_SETUP,
    SHIFT,
    CS_HOLD,
    PROCESS
  } state_e;

  state_e          state_q, state_d;
  logic [PW-1:0]   per_q, per_d;
  logic [DW-1:0]   cnt_q, cnt_d;
  logic [2:0]      bit_q, bit_d;
  logic [7:0]      shreg_q, shreg_d;
  logic [3:0][6:0] win_q, win_d;
  logic            fill_q, fill_d;
  logic [6:0]      temp_q, temp_d;
  logic            valid_q, valid_d;
  logic            fault_q, fault_d;

  logic            tick;
  logic            trigger;
  logic [6:0]      sample;
  logic [8:0]      sum;

  assign tick    = (per_q == P_LAST);
  assign trigger = tick | sample_now;
  assign per_d   = tick ? '0 : per_q + 1'b1;

  assign sens_cs_n    = !((state_q == CS_SETUP) ||
                          (state_q == SHIFT) ||
                          (state_q == CS_HOLD));
  assign sens_sclk    = (state_q == SHIFT) && (cnt_q >= HI_START);
  assign temperature  = temp_q;
  assign temp_valid   = valid_q;
  assign sensor_fault = fault_q;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    bit_d   = bit_q;
    shreg_d = shreg_q;
    win_d   = win_q;
    fill_d  = fill_q;
    temp_d  = temp_q;
    valid_d = 1'b0;
    fault_d = fault_q;
    sample  = '0;
    sum     = '0;
    unique case (state_q)
      IDLE: begin
        cnt_d = '0;
        if (trigger) state_d = CS_SETUP;
      end
      CS_SETUP: begin
        if (cnt_q == PH_END) begin
          cnt_d   = '0;
          bit_d   = '0;
          state_d = SHIFT;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      SHIFT: begin
        // capture on the cycle sclk rises
        if (cnt_q == HI_START) shreg_d = {shreg_q[6:0], sens_sdo};
        if (cnt_q == BIT_END) begin
          cnt_d = '0;
          if (bit_q == 3'd7) state_d = CS_HOLD;
          else bit_d = bit_q + 1'b1;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      CS_HOLD: begin
        if (cnt_q == PH_END) begin
          cnt_d   = '0;
          state_d = PROCESS;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      PROCESS: begin
        state_d = IDLE;
        if (shreg_q == 8'hFF) begin
          fault_d = 1'b1;
        end else begin
          fault_d = 1'b0;
          valid_d = 1'b1;
          sample  = shreg_q[7] ? 7'd0 : shreg_q[6:0];
          if (!fill_q) win_d = {4{sample}};
          else win_d = {win_q[2:0], sample};
          fill_d = 1'b1;
          sum    = {2'b00, win_d[0]} + {2'b00, win_d[1]} +
                   {2'b00, win_d[2]} + {2'b00, win_d[3]};
          temp_d = sum[8:2];
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      per_q   <= '0;
      cnt_q   <= '0;
      bit_q   <= '0;
      shreg_q <= '0;
      win_q   <= '0;
      fill_q  <= 1'b0;
      temp_q  <= '0;
      valid_q <= 1'b0;
      fault_q <= 1'b0;
    end else begin
      state_q <= state_d;
      per_q   <= per_d;
      cnt_q   <= cnt_d;
      bit_q   <= bit_d;
      shreg_q <= shreg_d;
      win_q   <= win_d;
      fill_q  <= fill_d;
      temp_q  <= temp_d;
      valid_q <= valid_d;
      fault_q <= fault_d;
    end
  end

endmodule

// File: tb/tb_temp_sensor_frontend.sv
// Bench for temp_sensor_frontend: behavioural sensor, queue-based
// averaging model and per-transaction timing monitor.
module tb_temp_sensor_frontend;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       sample_now = 1'b0;
  logic       sens_sdo = 1'b0;
  logic       sens_cs_n;
  logic       sens_sclk;
  logic [6:0] temperature;
  logic       temp_valid;
  logic       sensor_fault;

  temp_sensor_frontend dut (
    .clk          (clk),
    .reset        (reset),
    .sample_now   (sample_now),
    .sens_sdo     (sens_sdo),
    .sens_cs_n    (sens_cs_n),
    .sens_sclk    (sens_sclk),
    .temperature  (temperature),
    .temp_valid   (temp_valid),
    .sensor_fault (sensor_fault)
  );

  always #5 clk = ~clk;

  int errs = 0;
  int checks = 0;

  task automatic chk(input string tag, input int got, input int exp);
    checks++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // sensor: loads its byte on cs_n fall, shifts on sclk fall
  logic [7:0] sens_val = 8'd0;
  logic [7:0] sh = 8'd0;
  logic [7:0] latched = 8'd0;

  always @(negedge sens_cs_n) begin
    sh = sens_val;
    latched = sens_val;
    sens_sdo = sh[7];
  end

  always @(negedge sens_sclk) begin
    sh = {sh[6:0], 1'b0};
    sens_sdo = sh[7];
  end

  // reference model
  int mwin[$];
  bit mfill = 1'b0;
  int mtemp = 0;
  int mfault = 0;
  int exp_nvalid = 0;

  task automatic model_reset();
    mwin.delete();
    mfill = 1'b0;
    mtemp = 0;
    mfault = 0;
  endtask

  task automatic model_apply(input int raw);
    int s;
    int total;
    if (raw == 255) begin
      mfault = 1;
    end else begin
      mfault = 0;
      s = (raw >= 128) ? 0 : raw;
      if (!mfill) begin
        mwin = '{s, s, s, s};
        mfill = 1'b1;
      end else begin
        mwin.push_back(s);
        void'(mwin.pop_front());
      end
      total = 0;
      foreach (mwin[i]) total += mwin[i];
      mtemp = total / 4;
      exp_nvalid++;
    end
  endtask

  // cycle counters
  int pc = 0;
  int pmod = 0;

  always @(posedge clk) begin
    pc++;
    if (!reset) pmod = 0;
    else pmod = (pmod == 999) ? 0 : pmod + 1;
  end

  // transaction monitor
  bit in_txn = 1'b0;
  bit pend = 1'b0;
  int exp_v = 0;
  int low_len, nhigh, hi_run, hi_ok, t_start;
  int starts = 0;
  int done_cnt = 0;
  int nvalid = 0;

  always @(negedge clk) begin
    if (!reset) begin
      in_txn = 1'b0;
      pend = 1'b0;
    end else begin
      if (temp_valid) nvalid++;
      if (pend) begin
        pend = 1'b0;
        chk("valid", int'(temp_valid), exp_v);
        chk("temp", int'(temperature), mtemp);
        chk("fault", int'(sensor_fault), mfault);
        chk("cs_to_valid", pc - t_start, 73);
        done_cnt++;
      end
      if (!sens_cs_n) begin
        if (!in_txn) begin
          in_txn = 1'b1;
          starts++;
          low_len = 0;
          nhigh = 0;
          hi_run = 0;
          hi_ok = 1;
          t_start = pc;
        end
        low_len++;
        if (sens_sclk) begin
          hi_run++;
        end else if (hi_run != 0) begin
          if (hi_run != 4) hi_ok = 0;
          nhigh++;
          hi_run = 0;
        end
      end else if (in_txn) begin
        in_txn = 1'b0;
        chk("cs_low_len", low_len, 72);
        chk("sclk_pulses", nhigh, 8);
        chk("sclk_width", hi_ok, 1);
        model_apply(int'(latched));
        exp_v = (latched != 8'hFF) ? 1 : 0;
        pend = 1'b1;
      end
    end
  end

  task automatic wait_done(input int d0);
    for (int i = 0; i < 400 && done_cnt == d0; i++) @(negedge clk);
    chk("done_timeout", int'(done_cnt > d0), 1);
  endtask

  task automatic wait_pmod(input int v);
    for (int i = 0; i < 1100 && pmod != v; i++) @(negedge clk);
    chk("pmod_timeout", pmod, v);
  endtask

  task automatic wait_valid(input int t0, input int lat, input string tag);
    for (int i = 0; i < 200 && !temp_valid; i++) @(negedge clk);
    chk(tag, pc - t0, lat);
  endtask

  task automatic pulse_now();
    @(negedge clk);
    sample_now = 1'b1;
    @(negedge clk);
    sample_now = 1'b0;
  endtask

  task automatic do_read(input int v);
    int d0;
    sens_val = 8'(v);
    d0 = done_cnt;
    pulse_now();
    wait_done(d0);
  endtask

  int seq_in[4] = '{24, 28, 20, 32};
  int seq_exp[4] = '{24, 25, 24, 26};

  initial begin
    int s0;
    int t0;
    int n;
    bit prev;
    int r;

    sens_val = 8'd24;
    repeat (3) @(negedge clk);
    chk("rst_cs_n", int'(sens_cs_n), 1);
    chk("rst_sclk", int'(sens_sclk), 0);
    chk("rst_temp", int'(temperature), 0);
    chk("rst_valid", int'(temp_valid), 0);
    chk("rst_fault", int'(sensor_fault), 0);
    reset = 1'b1;

    // first automatic tick
    wait_pmod(999);
    t0 = pc;
    @(negedge clk);
    wait_valid(t0, 74, "tick_latency");
    chk("first_temp", int'(temperature), 24);
    @(negedge clk);

    // averaging with truncation
    foreach (seq_in[i]) begin
      do_read(seq_in[i]);
      chk("avg_seq", int'(temperature), seq_exp[i]);
    end

    // faulty sensor then recovery
    do_read(255);
    chk("ff_fault", int'(sensor_fault), 1);
    chk("ff_hold", int'(temperature), 26);
    do_read(22);
    chk("ff_clear", int'(sensor_fault), 0);

    // negative clamp and full scale
    repeat (4) do_read(0);
    do_read(8'hF6);
    chk("neg_clamp", int'(temperature), 0);
    repeat (4) do_read(127);
    chk("full_scale", int'(temperature), 127);

    // tick and sample_now coincide
    sens_val = 8'd40;
    wait_pmod(999);
    s0 = starts;
    t0 = pc;
    sample_now = 1'b1;
    @(negedge clk);
    sample_now = 1'b0;
    wait_valid(t0, 74, "coincide_latency");
    repeat (150) @(negedge clk);
    chk("coincide_one_txn", starts - s0, 1);

    // sample_now during shift is dropped
    sens_val = 8'd50;
    wait_pmod(100);
    s0 = starts;
    pulse_now();
    repeat (20) @(negedge clk);
    chk("mid_in_shift", int'(sens_cs_n), 0);
    pulse_now();
    repeat (200) @(negedge clk);
    chk("mid_one_txn", starts - s0, 1);

    // reset during bit 3
    sens_val = 8'd100;
    wait_pmod(100);
    pulse_now();
    n = 0;
    prev = 1'b0;
    for (int i = 0; i < 100 && n < 4; i++) begin
      @(negedge clk);
      if (sens_sclk && !prev) n++;
      prev = sens_sclk;
    end
    chk("bit3_reached", n, 4);
    #2 reset = 1'b0;
    #1;
    chk("abort_cs_n", int'(sens_cs_n), 1);
    chk("abort_sclk", int'(sens_sclk), 0);
    model_reset();
    repeat (3) @(negedge clk);
    reset = 1'b1;
    do_read(30);
    chk("refill_temp", int'(temperature), 30);

    // randomized readings
    for (int i = 0; i < 24; i++) begin
      r = ($urandom_range(0, 7) == 0) ? 255 : int'($urandom_range(0, 255));
      do_read(r);
    end

    repeat (5) @(negedge clk);
    chk("valid_count", nvalid, exp_nvalid);
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
